mem_arbiter: RTL and testbench
==============================

Name: mem_arbiter

Overview:
- Two-client to one-port memory arbiter sitting directly downstream of the instruction cache (client 0) and data cache (client 1).
- Merges both caches' word-granularity memory interfaces onto the single external memory port.
- Grant is locked for the duration of a line refill burst or write, and in-order read responses are routed back to the owning cache.
- Round-robin fairness between the two caches.

Parameters:
- MAX_OUT, 4, maximum accepted-but-unanswered reads; equals words per cache line.
- CW, 3, outstanding counter width; must hold 0..MAX_OUT.

Ports:
- i_clk  input  1  clock
- i_rst  input  1  asynchronous, active-high reset
- i_c0_addr  input  32  icache memory address (word aligned)
- i_c0_ren  input  1  icache read request
- i_c0_wen  input  1  icache write request (tied 0 in practice; still arbitrated)
- i_c0_wdata  input  32  icache write data
- o_c0_ready  output  1  memory ready as seen by icache
- o_c0_rdata  output  32  read data to icache
- o_c0_valid  output  1  read response valid to icache
- i_c1_addr, i_c1_ren, i_c1_wen, i_c1_wdata, o_c1_ready, o_c1_rdata, o_c1_valid: same as c0, data cache
- o_mem_addr  output  32  to memory
- o_mem_ren  output  1  to memory
- o_mem_wen  output  1  to memory
- o_mem_wdata  output  32  to memory
- i_mem_ready  input  1  memory can accept a request this cycle
- i_mem_rdata  input  32  memory read data
- i_mem_valid  input  1  memory read response valid (in order, ≥1 cycle after acceptance)

Behaviour:
- Registered state:
  - locked (1b), owner (1b), last (1b, last granted client), out (CW bits).
- Reset values:
  - locked=0, owner=0, last=1 (so c0 wins first tie), out=0.
  - All outputs 0 while i_rst is high. Reset is asynchronous and takes effect immediately.
- Request: req_x = i_cx_ren | i_cx_wen.
- Effective grant g (combinational, same cycle):
  - if locked: g=owner;
  - else if only one client has req: that client;
  - else if both have req: ~last;
  - else: no grant.
- Datapath (zero-latency mux):
  - o_mem_addr/ren/wen/wdata = granted client's signals.
  - With no grant, ren=wen=0 and addr/wdata=0.
- Ready: o_cg_ready = i_mem_ready & (out < MAX_OUT | !ren_g). The non-granted client sees ready=0.
- Acceptance: a request is accepted when (ren|wen) of g is high and the forwarded ready is high. An accepted read increments out; a write does not.
- Response routing: i_mem_valid forwards rdata/valid to owner only. All other o_cx_valid outputs are 0. rdata is passed through to both clients; it is meaningful only with valid.
- out update:
  - +1 on accepted read, −1 on i_mem_valid.
  - Both in the same cycle: unchanged.
  - i_mem_valid with out==0: dropped, out stays 0. This covers stray responses after reset.
- Lock:
  - On a clock edge with a grant and req_g: locked<=1, owner<=g, last<=g.
  - While locked, release (locked<=0) at the edge where req_owner==0 and out_next==0.
  - Requests are held through stalls, so the lock spans the whole refill burst: first ren through the 4th valid.
- Handoff:
  - On the release cycle the other client is not granted combinationally.
  - It is granted the following cycle (1-cycle bubble). This guarantees in-order responses never cross owners.
- A client may drop ren mid-burst while out>0; the grant stays with it until out returns to 0.
- Simultaneous ren and wen from one client is illegal; behaviour is undefined.

Test Plan:
- Icache alone: i_c0_ren held, addr 0x100/0x104/0x108/0x10C, mem ready=1, valid 2 cycles after each -> 4 o_c0_valid pulses with matching rdata; o_c1_valid never set; locked drops after 4th valid.
- Both request in same cycle after reset -> c0 granted (last=1). After c0 releases and both request again -> c1 granted; o_c0_ready=0 throughout c1's burst.
- Dcache write hit 0x2000, wdata 0xDEADBEEF, ready held 0 for 3 cycles -> o_mem_wen=1 with stable addr/data for 4 cycles; out stays 0; release on the edge after wen drops.
- Memory ready=1 and valid withheld -> out reaches 4, o_c0_ready forced 0 while ren still high; first valid -> out=3, ready=1 again.
- Reset asserted with out=2 mid-burst -> outputs 0 immediately; after release out=0, locked=0; two late i_mem_valid pulses produce no o_cx_valid.
- c1 requests while c0 owns with out=1 -> c1 sees ready=0 until c0's last valid, then one bubble cycle, then c1 granted.

Source files
------------

// File: rtl/mem_arbiter.sv
// Two-client (icache/dcache) to one-port memory arbiter with burst grant locking,
// round-robin tie-break and in-order read response routing back to the owning cache.
module mem_arbiter #(
    parameter int MAX_OUT = 4,
    parameter int CW      = 3
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic [31:0] i_c0_addr,
    input  logic        i_c0_ren,
    input  logic        i_c0_wen,
    input  logic [31:0] i_c0_wdata,
    output logic        o_c0_ready,
    output logic [31:0] o_c0_rdata,
    output logic        o_c0_valid,
    input  logic [31:0] i_c1_addr,
    input  logic        i_c1_ren,
    input  logic        i_c1_wen,
    input  logic [31:0] i_c1_wdata,
    output logic        o_c1_ready,
    output logic [31:0] o_c1_rdata,
    output logic        o_c1_valid,
    output logic [31:0] o_mem_addr,
    output logic        o_mem_ren,
    output logic        o_mem_wen,
    output logic [31:0] o_mem_wdata,
    input  logic        i_mem_ready,
    input  logic [31:0] i_mem_rdata,
    input  logic        i_mem_valid
);

    typedef enum logic {ST_IDLE, ST_LOCKED} state_t;

    state_t        state, state_next;
    logic          owner, owner_next;
    logic          last, last_next;
    logic [CW-1:0] out, out_next;

    logic req0, req1, req_owner;
    logic gnt_vld, gnt;
    logic ren_g, wen_g, req_g, ready_g;
    logic acc_rd, rsp;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state <= ST_IDLE;
            owner <= 1'b0;
            last  <= 1'b1;
            out   <= '0;
        end else begin
            state <= state_next;
            owner <= owner_next;
            last  <= last_next;
            out   <= out_next;
        end
    end

    // Grant is combinational; a locked arbiter always points at the owner.
    always_comb begin
        req0      = i_c0_ren | i_c0_wen;
        req1      = i_c1_ren | i_c1_wen;
        req_owner = owner ? req1 : req0;
        gnt_vld   = 1'b0;
        gnt       = 1'b0;
        if (state == ST_LOCKED) begin
            gnt_vld = 1'b1;
            gnt     = owner;
        end else if (req0 && req1) begin
            gnt_vld = 1'b1;
            gnt     = ~last;
        end else if (req0) begin
            gnt_vld = 1'b1;
        end else if (req1) begin
            gnt_vld = 1'b1;
            gnt     = 1'b1;
        end
        ren_g   = gnt_vld & (gnt ? i_c1_ren : i_c0_ren);
        wen_g   = gnt_vld & (gnt ? i_c1_wen : i_c0_wen);
        req_g   = ren_g | wen_g;
        ready_g = i_mem_ready & ((out < CW'(MAX_OUT)) | ~ren_g);
        acc_rd  = ren_g & ready_g;
        // Responses with nothing outstanding are strays and are discarded.
        rsp     = i_mem_valid & (out != '0);
        out_next = out;
        if (acc_rd && !rsp)
            out_next = out + CW'(1);
        else if (!acc_rd && rsp)
            out_next = out - CW'(1);
    end

    always_comb begin
        state_next = state;
        owner_next = owner;
        last_next  = last;
        if (state == ST_LOCKED && !req_owner && out_next == '0) begin
            state_next = ST_IDLE;
        end else if (gnt_vld && req_g) begin
            state_next = ST_LOCKED;
            owner_next = gnt;
            last_next  = gnt;
        end
    end

    always_comb begin
        o_mem_addr  = '0;
        o_mem_ren   = 1'b0;
        o_mem_wen   = 1'b0;
        o_mem_wdata = '0;
        o_c0_ready  = 1'b0;
        o_c1_ready  = 1'b0;
        o_c0_rdata  = '0;
        o_c1_rdata  = '0;
        o_c0_valid  = 1'b0;
        o_c1_valid  = 1'b0;
        if (!i_rst) begin
            if (gnt_vld) begin
                o_mem_addr  = gnt ? i_c1_addr  : i_c0_addr;
                o_mem_wdata = gnt ? i_c1_wdata : i_c0_wdata;
                o_mem_ren   = ren_g;
                o_mem_wen   = wen_g;
            end
            o_c0_ready = gnt_vld & ~gnt & ready_g;
            o_c1_ready = gnt_vld &  gnt & ready_g;
            o_c0_rdata = i_mem_rdata;
            o_c1_rdata = i_mem_rdata;
            o_c0_valid = rsp & ~owner;
            o_c1_valid = rsp &  owner;
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed vector table, hand-written corner sequences and
// randomized traffic against a queue-based reference model.
module tb_mem_arbiter;

    localparam int MAX_OUT = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] c0_addr = '0, c0_wdata = '0, c1_addr = '0, c1_wdata = '0;
    logic        c0_ren = 1'b0, c0_wen = 1'b0, c1_ren = 1'b0, c1_wen = 1'b0;
    logic        mem_ready = 1'b0, mem_valid = 1'b0;
    logic [31:0] mem_rdata = '0;

    logic        o_c0_ready, o_c0_valid, o_c1_ready, o_c1_valid;
    logic [31:0] o_c0_rdata, o_c1_rdata;
    logic [31:0] o_mem_addr, o_mem_wdata;
    logic        o_mem_ren, o_mem_wen;

    int n_pass = 0;
    int n_total = 0;

    mem_arbiter #(.MAX_OUT(MAX_OUT), .CW(3)) dut (
        .i_clk(clk), .i_rst(rst),
        .i_c0_addr(c0_addr), .i_c0_ren(c0_ren), .i_c0_wen(c0_wen), .i_c0_wdata(c0_wdata),
        .o_c0_ready(o_c0_ready), .o_c0_rdata(o_c0_rdata), .o_c0_valid(o_c0_valid),
        .i_c1_addr(c1_addr), .i_c1_ren(c1_ren), .i_c1_wen(c1_wen), .i_c1_wdata(c1_wdata),
        .o_c1_ready(o_c1_ready), .o_c1_rdata(o_c1_rdata), .o_c1_valid(o_c1_valid),
        .o_mem_addr(o_mem_addr), .o_mem_ren(o_mem_ren), .o_mem_wen(o_mem_wen),
        .o_mem_wdata(o_mem_wdata), .i_mem_ready(mem_ready), .i_mem_rdata(mem_rdata),
        .i_mem_valid(mem_valid)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] addr;
        logic        ren;
        logic        wen;
        logic [31:0] wdata;
        logic        rdy0, rdy1, v0, v1;
        logic [31:0] rd0, rd1;
    } obs_t;

    typedef struct {
        logic        rst, r0;
        logic [31:0] a0;
        logic        r1;
        logic [31:0] a1;
        logic        mval;
        logic [31:0] mrdata;
        logic [31:0] e_addr;
        logic        e_ren, e_rdy0, e_rdy1, e_v0, e_v1;
    } vec_t;

    // Reference model: lock holder (-1 = free), last winner, queue of owners of pending reads.
    int m_lock = -1;
    int m_last = 1;
    int m_pend[$];

    function automatic bit req_of(int c);
        return (c == 0) ? (c0_ren | c0_wen) : (c1_ren | c1_wen);
    endfunction

    function automatic bit ren_of(int c);
        return (c == 0) ? c0_ren : c1_ren;
    endfunction

    function automatic int model_grant();
        if (m_lock >= 0) return m_lock;
        if (req_of(0) && req_of(1)) return 1 - m_last;
        if (req_of(0)) return 0;
        if (req_of(1)) return 1;
        return -1;
    endfunction

    function automatic bit model_ready(int g);
        return mem_ready && (m_pend.size() < MAX_OUT || !ren_of(g));
    endfunction

    function automatic obs_t model_expect();
        obs_t e;
        int g;
        e = '0;
        if (rst) return e;
        g = model_grant();
        if (g == 0) begin
            e.addr = c0_addr; e.ren = c0_ren; e.wen = c0_wen; e.wdata = c0_wdata;
            e.rdy0 = model_ready(0);
        end else if (g == 1) begin
            e.addr = c1_addr; e.ren = c1_ren; e.wen = c1_wen; e.wdata = c1_wdata;
            e.rdy1 = model_ready(1);
        end
        if (mem_valid && m_pend.size() != 0) begin
            if (m_pend[0] == 0) e.v0 = 1'b1;
            else e.v1 = 1'b1;
        end
        e.rd0 = mem_rdata;
        e.rd1 = mem_rdata;
        return e;
    endfunction

    task automatic model_edge();
        int g;
        bit acc, pop;
        if (rst) begin
            m_lock = -1;
            m_last = 1;
            m_pend.delete();
            return;
        end
        g   = model_grant();
        acc = (g >= 0) && ren_of(g) && model_ready(g);
        pop = mem_valid && m_pend.size() != 0;
        if (pop) void'(m_pend.pop_front());
        if (acc) m_pend.push_back(g);
        if (m_lock >= 0 && !req_of(m_lock) && m_pend.size() == 0) begin
            m_lock = -1;
        end else if (g >= 0 && req_of(g)) begin
            m_lock = g;
            m_last = g;
        end
    endtask

    function automatic obs_t dut_obs();
        obs_t a;
        a.addr = o_mem_addr; a.ren = o_mem_ren; a.wen = o_mem_wen; a.wdata = o_mem_wdata;
        a.rdy0 = o_c0_ready; a.rdy1 = o_c1_ready; a.v0 = o_c0_valid; a.v1 = o_c1_valid;
        a.rd0 = o_c0_rdata; a.rd1 = o_c1_rdata;
        return a;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act !== exp) $display("FAIL %s: got %h, expected %h", name, act, exp);
        else n_pass++;
    endtask

    task automatic chk_obs(input string name, input obs_t act, input obs_t exp);
        n_total++;
        if (act !== exp) $display("FAIL %s: got %h, expected %h", name, act, exp);
        else n_pass++;
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        @(negedge clk);
    endtask

    task automatic clr();
        c0_addr = '0; c0_ren = 1'b0; c0_wen = 1'b0; c0_wdata = '0;
        c1_addr = '0; c1_ren = 1'b0; c1_wen = 1'b0; c1_wdata = '0;
        mem_valid = 1'b0; mem_rdata = '0; mem_ready = 1'b1;
    endtask

    task automatic do_reset();
        clr();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        vec_t tv[15];
        // icache burst, reset, tie to c0, handoff, tie to c1, handoff back
        tv[0]  = '{1'b0, 1'b1, 32'h100, 1'b0, 32'h0,   1'b0, 32'h0,     32'h100, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        tv[1]  = '{1'b0, 1'b1, 32'h104, 1'b0, 32'h0,   1'b0, 32'h0,     32'h104, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        tv[2]  = '{1'b0, 1'b1, 32'h108, 1'b0, 32'h0,   1'b1, 32'hA100,  32'h108, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
        tv[3]  = '{1'b0, 1'b1, 32'h10C, 1'b0, 32'h0,   1'b1, 32'hA104,  32'h10C, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
        tv[4]  = '{1'b0, 1'b0, 32'h0,   1'b0, 32'h0,   1'b1, 32'hA108,  32'h0,   1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
        tv[5]  = '{1'b0, 1'b0, 32'h0,   1'b0, 32'h0,   1'b1, 32'hA10C,  32'h0,   1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
        tv[6]  = '{1'b0, 1'b0, 32'h0,   1'b0, 32'h0,   1'b0, 32'h0,     32'h0,   1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        tv[7]  = '{1'b1, 1'b1, 32'h200, 1'b1, 32'h300, 1'b0, 32'h0,     32'h0,   1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        tv[8]  = '{1'b0, 1'b1, 32'h200, 1'b1, 32'h300, 1'b0, 32'h0,     32'h200, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        tv[9]  = '{1'b0, 1'b0, 32'h0,   1'b1, 32'h300, 1'b0, 32'h0,     32'h0,   1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        tv[10] = '{1'b0, 1'b0, 32'h0,   1'b1, 32'h300, 1'b1, 32'hA200,  32'h0,   1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
        tv[11] = '{1'b0, 1'b1, 32'h204, 1'b1, 32'h300, 1'b0, 32'h0,     32'h300, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
        tv[12] = '{1'b0, 1'b1, 32'h204, 1'b0, 32'h0,   1'b0, 32'h0,     32'h0,   1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        tv[13] = '{1'b0, 1'b1, 32'h204, 1'b0, 32'h0,   1'b1, 32'hA300,  32'h0,   1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
        tv[14] = '{1'b0, 1'b1, 32'h204, 1'b0, 32'h0,   1'b0, 32'h0,     32'h204, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};

        // Outputs must be 0 during reset even with live inputs
        @(negedge clk);
        c0_ren = 1'b1; c0_addr = 32'h40; mem_ready = 1'b1; mem_valid = 1'b1; mem_rdata = 32'h1111;
        #1 chk_obs("reset_out", dut_obs(), '0);
        tick();
        clr();
        rst = 1'b0;

        for (int i = 0; i < 15; i++) begin
            rst = tv[i].rst; c0_ren = tv[i].r0; c0_addr = tv[i].a0;
            c1_ren = tv[i].r1; c1_addr = tv[i].a1;
            mem_ready = 1'b1; mem_valid = tv[i].mval; mem_rdata = tv[i].mrdata;
            #1;
            chk($sformatf("tbl%0d", i),
                64'({o_mem_addr, o_mem_ren, o_mem_wen, o_c0_ready, o_c1_ready, o_c0_valid, o_c1_valid}),
                64'({tv[i].e_addr, tv[i].e_ren, 1'b0, tv[i].e_rdy0, tv[i].e_rdy1, tv[i].e_v0, tv[i].e_v1}));
            if (tv[i].mval)
                chk($sformatf("tbl%0d_rdata", i), {o_c0_rdata, o_c1_rdata}, {tv[i].mrdata, tv[i].mrdata});
            tick();
        end
        rst = 1'b0;

        // dcache write held through 3 stall cycles
        do_reset();
        c1_wen = 1'b1; c1_addr = 32'h2000; c1_wdata = 32'hDEADBEEF; mem_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (i == 3) mem_ready = 1'b1;
            #1;
            chk("wr_cmd", 64'({o_mem_wen, o_mem_ren}), 64'(2'b10));
            chk("wr_addr_data", {o_mem_addr, o_mem_wdata}, {32'h2000, 32'hDEADBEEF});
            chk("wr_ready", 64'(o_c1_ready), 64'(i == 3));
            tick();
        end
        c1_wen = 1'b0; c0_ren = 1'b1; c0_addr = 32'h400;
        #1 chk("wr_hold", 64'({o_c0_ready, o_mem_ren, o_mem_wen}), 64'(3'b000));
        tick();
        #1 chk("wr_handoff", 64'({o_c0_ready, o_mem_ren, o_mem_addr}), 64'({2'b11, 32'h400}));

        // outstanding limit
        do_reset();
        c0_ren = 1'b1; c0_addr = 32'h500;
        for (int i = 0; i < 4; i++) begin
            #1 chk("lim_fill", 64'(o_c0_ready), 64'(1'b1));
            tick();
        end
        for (int i = 0; i < 2; i++) begin
            #1 chk("lim_stall", 64'({o_c0_ready, o_mem_ren}), 64'(2'b01));
            tick();
        end
        mem_valid = 1'b1; mem_rdata = 32'h5151;
        #1 chk("lim_valid", 64'({o_c0_ready, o_c0_valid, o_c0_rdata}), 64'({2'b01, 32'h5151}));
        tick();
        mem_valid = 1'b0;
        #1 chk("lim_resume", 64'(o_c0_ready), 64'(1'b1));

        // asynchronous reset in the middle of a burst
        do_reset();
        c0_ren = 1'b1; c0_addr = 32'h600;
        tick();
        tick();
        mem_valid = 1'b1; mem_rdata = 32'h7777;
        #1 chk("rst_pre", 64'({o_mem_ren, o_c0_valid}), 64'(2'b11));
        #1 rst = 1'b1;
        #1 chk_obs("rst_async", dut_obs(), '0);
        tick();
        rst = 1'b0; c0_ren = 1'b0;
        for (int i = 0; i < 2; i++) begin
            #1 chk("rst_stray", 64'({o_c0_valid, o_c1_valid}), 64'(2'b00));
            tick();
        end
        mem_valid = 1'b0; c1_ren = 1'b1; c1_addr = 32'h700;
        #1 chk("rst_unlocked", 64'({o_c1_ready, o_mem_addr}), 64'({1'b1, 32'h700}));

        // c1 waits while c0 owns with one read outstanding
        do_reset();
        c0_ren = 1'b1; c0_addr = 32'h800;
        tick();
        c0_ren = 1'b0; c1_ren = 1'b1; c1_addr = 32'h900;
        for (int i = 0; i < 2; i++) begin
            #1 chk("ho_wait", 64'({o_c1_ready, o_mem_ren}), 64'(2'b00));
            tick();
        end
        mem_valid = 1'b1; mem_rdata = 32'h55;
        #1 chk("ho_last", 64'({o_c0_valid, o_c1_valid, o_c1_ready}), 64'(3'b100));
        tick();
        mem_valid = 1'b0;
        #1 chk("ho_grant", 64'({o_c1_ready, o_mem_ren, o_mem_addr}), 64'({2'b11, 32'h900}));

        // randomized traffic against the reference model
        do_reset();
        for (int n = 0; n < 3000; n++) begin
            int k0, k1;
            rst = ($urandom_range(0, 199) == 0);
            k0 = $urandom_range(0, 7);
            k1 = $urandom_range(0, 7);
            c0_ren = (k0 >= 3 && k0 <= 6); c0_wen = (k0 == 7);
            c1_ren = (k1 >= 3 && k1 <= 6); c1_wen = (k1 == 7);
            c0_addr = $urandom & 32'hFFFF_FFFC; c0_wdata = $urandom;
            c1_addr = $urandom & 32'hFFFF_FFFC; c1_wdata = $urandom;
            mem_ready = ($urandom_range(0, 3) != 0);
            mem_valid = ($urandom_range(0, 2) == 0);
            mem_rdata = $urandom;
            #1 chk_obs($sformatf("rand%0d", n), dut_obs(), model_expect());
            tick();
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
